// File: rtl/led_round_controller.sv
// LED memory-game round sequencer: shows an LFSR-derived 3-bit pattern, opens a
// response window for the scorer, accumulates hits, and steps through rounds.
module led_round_controller #(
  parameter int unsigned SHOW_CYCLES = 50,
  parameter int unsigned RESP_CYCLES = 200,
  parameter int unsigned NUM_ROUNDS  = 10,
  parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       Point,
  input  logic       valid,
  output logic [2:0] LED,
  output logic [7:0] score,
  output logic [3:0] round,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {IDLE, SHOW, RESP, NEXT, DONE} state_e;

  localparam logic [15:0] SHOW_LAST  = 16'(SHOW_CYCLES - 1);
  localparam logic [15:0] RESP_LAST  = 16'(RESP_CYCLES - 1);
  localparam logic [3:0]  LAST_ROUND = 4'(NUM_ROUNDS);

  state_e      state_q, state_d;
  logic [7:0]  lfsr_q, lfsr_d;
  logic [2:0]  pat_q, pat_d;
  logic [2:0]  led_q, led_d;
  logic [7:0]  score_q, score_d;
  logic [3:0]  round_q, round_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  rcnt_q, rcnt_d;
  logic [2:0]  captured;

  // Fibonacci LFSR x^8+x^6+x^5+x^4+1; an all-zero pattern would show nothing, so it maps to 001.
  assign lfsr_d   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign captured = (lfsr_q[2:0] == 3'b000) ? 3'b001 : lfsr_q[2:0];

  always_comb begin
    // NOTE: every variable gets a default first so no path can leave one unassigned and infer a latch.
    state_d = state_q;
    pat_d   = pat_q;
    score_d = score_q;
    round_d = round_q;
    cnt_d   = cnt_q + 16'd1;
    rcnt_d  = rcnt_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = SHOW;
          round_d = 4'd1;
          score_d = 8'd0;
          pat_d   = captured;
        end
      end
      SHOW: begin
        if (cnt_q == SHOW_LAST) state_d = RESP;
      end
      RESP: begin
        if (valid && rcnt_q != 2'd3) begin
          rcnt_d = rcnt_q + 2'd1;
          if (Point && score_q != 8'hFF) score_d = score_q + 8'd1;
          if (rcnt_q == 2'd2) state_d = NEXT;
        end
        if (cnt_q == RESP_LAST) state_d = NEXT;
      end
      NEXT: begin
        if (round_q == LAST_ROUND) begin
          state_d = DONE;
        end else begin
          state_d = SHOW;
          round_d = round_q + 4'd1;
          pat_d   = captured;
        end
      end
      default: state_d = IDLE;
    endcase

    // Every state entry starts its dwell and response counts from zero.
    if (state_d != state_q) begin
      cnt_d  = 16'd0;
      rcnt_d = 2'd0;
    end

    led_d  = (state_d == SHOW || state_d == RESP) ? pat_d : 3'b000;
    busy_d = (state_d == SHOW || state_d == RESP || state_d == NEXT);
    done_d = (state_d == DONE);
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      lfsr_q  <= LFSR_SEED;
      pat_q   <= 3'b000;
      led_q   <= 3'b000;
      score_q <= 8'd0;
      round_q <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= 16'd0;
      rcnt_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      pat_q   <= pat_d;
      led_q   <= led_d;
      score_q <= score_d;
      round_q <= round_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      rcnt_q  <= rcnt_d;
    end
  end

  assign LED   = led_q;
  assign score = score_q;
  assign round = round_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule
